regfile_access_sched: RTL and testbench
=======================================

// Module: regfile_access_sched
// PURPOSE
//  Schedules the register-file read selects (Sel_A/Sel_B) and the single write port between the CPU core and a debug host.
//  The core has priority. Pending debug requests are guaranteed a slot after STARVE_LIMIT stalled cycles.
//  Sits between the control unit/debug UART and the register-file read mux + write decoder.
// PARAMETERS
//  DW            16  data width of registers / Data_B
//  STARVE_LIMIT  4   max consecutive core-won cycles while a debug request waits (>=1)
// PORTS
//  clk          in   1   system clock, all state on rising edge
//  reset_n      in   1   asynchronous active-low reset
//  core_req     in   1   core wants the ports this cycle
//  core_sel_a   in   5   core read select A
//  core_sel_b   in   6   core read select B
//  core_we      in   1   core write enable (qualified by core_req)
//  core_wsel    in   6   core write address
//  core_wdata   in   DW  core write data
//  core_stall   out  1   core request not granted this cycle; core must hold inputs
//  dbg_valid    in   1   debug request valid
//  dbg_ready    out  1   block can accept debug request
//  dbg_write    in   1   1=write, 0=read
//  dbg_addr     in   6   debug register address
//  dbg_wdata    in   DW  debug write data
//  dbg_rvalid   out  1   debug response valid (held until dbg_rready)
//  dbg_rready   in   1   host consumes response
//  dbg_rdata    out  DW  read data (0 for writes/errors)
//  dbg_err      out  1   response is an address error
//  Sel_A        out  5   to register-file read mux A
//  Sel_B        out  6   to register-file read mux B
//  Data_B       in   DW  read mux B output (combinational from Sel_B)
//  rf_we        out  1   register-file write strobe
//  rf_wsel      out  6   write address
//  rf_wdata     out  DW  write data
// BEHAVIOUR
//  Address map: readable 0..29, 34. Writable 0..27, 32, 33, 34. 28/29 (PI0/PI1) are read-only.
//  FSM IDLE/WAIT/RESP, starve_cnt (0..STARVE_LIMIT).
//  dbg_ready = (state==IDLE).
//  IDLE: dbg_valid&dbg_ready latches write/addr/wdata -> WAIT, starve_cnt=0.
//  WAIT, bad address: no port use, no stall -> RESP, err=1, rdata=0.
//  WAIT, good address:
//   - dbg_win = !core_req | (starve_cnt==STARVE_LIMIT).
//   - dbg_win: ports driven from latch: Sel_B=addr, Sel_A=core_sel_a, rf_we=write.
//   - dbg_win, read: Data_B captured into dbg_rdata at the edge. Then -> RESP, err=0.
//   - !dbg_win: starve_cnt++.
//  core_stall = core_req & dbg_win (WAIT state only). Else 0.
//  RESP: dbg_rvalid=1, rdata/err stable until the dbg_rready edge -> IDLE (rvalid=0). A new request is accepted the next cycle.
//  Otherwise ports pass the core inputs through.
//  rf_we = core_req & core_we & writable(core_wsel). Core writes to 28/29/undefined are silently dropped.
//  Latency: accept edge -> response at 2nd edge minimum; at most STARVE_LIMIT+2 edges.
//  Core read-after-debug-write in the following cycle sees the new value (write-port timing of the register file).
//  Reset: state=IDLE, starve_cnt=0, dbg_rvalid=0, dbg_rdata=0, dbg_err=0.
//  While reset_n low: rf_we=0, core_stall=0, dbg_ready=1.
//  Reset mid-request drops it; no write is issued.
//  Simultaneous dbg_valid in RESP: ignored (ready=0). Host must hold valid.
// STRUCTURE
//  Shared include ev22_regfile_defs.vh: R_PI0=28, R_PI1=29, R_32=32, R_33=33, R_WREG=34; FSM state encodings.
//  One sub-module regfile_addr_check: combinational, addr[5:0] -> readable, writable. Used for core and debug.
// TESTING
//  1. Debug read r5=16'hBEEF, core_req=0 -> Sel_B=5 in WAIT; rvalid at 2nd edge, rdata=BEEF, err=0.
//  2. Debug write r34=16'h1234 with core_req held 1, STARVE_LIMIT=4.
//     -> 4 core-won cycles, then 1 cycle core_stall=1, rf_we=1, rf_wsel=34, rf_wdata=1234.
//  3. Debug write addr 28 -> no rf_we, no stall; rvalid with err=1. Debug read 40 -> err=1, rdata=0.
//  4. Core write core_wsel=29, core_we=1 -> rf_we=0. core_wsel=33 -> rf_we=1 same cycle.
//  5. Hold dbg_rready=0 for 10 cycles -> rvalid/rdata stable, dbg_ready=0. Assert rready -> next cycle ready=1.
//  6. Assert reset_n=0 in WAIT -> rvalid=0, state IDLE, no write issued, dbg_ready=1 after release.

Source files
------------

// File: rtl/regfile_access_sched_pkg.sv
// Shared register-map constants and FSM encodings
// for the register-file access scheduler.
package regfile_access_sched_pkg;

    localparam logic [5:0] R_PI0  = 6'd28;
    localparam logic [5:0] R_PI1  = 6'd29;
    localparam logic [5:0] R_32   = 6'd32;
    localparam logic [5:0] R_33   = 6'd33;
    localparam logic [5:0] R_WREG = 6'd34;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/regfile_addr_check.sv
// Register-map decode: which addresses may be read
// and which may be written.
module regfile_addr_check
    import regfile_access_sched_pkg::*;
(
    input  logic [5:0] addr,
    output logic       readable,
    output logic       writable
);

    always_comb begin
        readable = (addr <= R_PI1) || (addr == R_WREG);
        // PI0/PI1 are inputs to the core, never written
        writable = (addr < R_PI0)
                || (addr == R_32)
                || (addr == R_33)
                || (addr == R_WREG);
    end

endmodule

// File: rtl/regfile_access_sched.sv
// Arbitrates register-file read selects and write port
// between the core (priority) and a debug host.
module regfile_access_sched
    import regfile_access_sched_pkg::*;
#(
    parameter int DW           = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          core_req,
    input  logic [4:0]    core_sel_a,
    input  logic [5:0]    core_sel_b,
    input  logic          core_we,
    input  logic [5:0]    core_wsel,
    input  logic [DW-1:0] core_wdata,
    output logic          core_stall,
    input  logic          dbg_valid,
    output logic          dbg_ready,
    input  logic          dbg_write,
    input  logic [5:0]    dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_rvalid,
    input  logic          dbg_rready,
    output logic [DW-1:0] dbg_rdata,
    output logic          dbg_err,
    output logic [4:0]    Sel_A,
    output logic [5:0]    Sel_B,
    input  logic [DW-1:0] Data_B,
    output logic          rf_we,
    output logic [5:0]    rf_wsel,
    output logic [DW-1:0] rf_wdata
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic [1:0]    state;
    logic [CW-1:0] starve_cnt;
    logic          lat_write;
    logic [5:0]    lat_addr;
    logic [DW-1:0] lat_wdata;

    logic core_wr_ok;
    logic core_rd_unused;
    logic dbg_rd_ok;
    logic dbg_wr_ok;
    logic dbg_ok;
    logic starve_full;
    logic in_wait;
    logic dbg_win;

    regfile_addr_check u_core_chk (
        .addr     (core_wsel),
        .readable (core_rd_unused),
        .writable (core_wr_ok)
    );

    regfile_addr_check u_dbg_chk (
        .addr     (lat_addr),
        .readable (dbg_rd_ok),
        .writable (dbg_wr_ok)
    );

    always_comb begin
        dbg_ok      = lat_write ? dbg_wr_ok : dbg_rd_ok;
        starve_full = (starve_cnt == CW'(STARVE_LIMIT));
        in_wait     = (state == ST_WAIT);
        dbg_win     = in_wait & dbg_ok
                    & (~core_req | starve_full);
    end

    always_comb begin
        Sel_A      = core_sel_a;
        Sel_B      = core_sel_b;
        rf_we      = reset_n & core_req & core_we & core_wr_ok;
        rf_wsel    = core_wsel;
        rf_wdata   = core_wdata;
        core_stall = 1'b0;
        if (dbg_win) begin
            Sel_B      = lat_addr;
            rf_we      = reset_n & lat_write;
            rf_wsel    = lat_addr;
            rf_wdata   = lat_wdata;
            core_stall = core_req;
        end
    end

    assign dbg_ready  = (state == ST_IDLE);
    assign dbg_rvalid = (state == ST_RESP);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            starve_cnt <= '0;
            lat_write  <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            dbg_rdata  <= '0;
            dbg_err    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (dbg_valid) begin
                        lat_write  <= dbg_write;
                        lat_addr   <= dbg_addr;
                        lat_wdata  <= dbg_wdata;
                        starve_cnt <= '0;
                        state      <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!dbg_ok) begin
                        dbg_err   <= 1'b1;
                        dbg_rdata <= '0;
                        state     <= ST_RESP;
                    end else if (dbg_win) begin
                        dbg_err   <= 1'b0;
                        dbg_rdata <= lat_write ? '0 : Data_B;
                        state     <= ST_RESP;
                    end else begin
                        starve_cnt <= starve_cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (dbg_rready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_access_sched.sv
// Directed self-checking bench for regfile_access_sched
// with a behavioural register-file model.
module tb_regfile_access_sched;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          core_req;
    logic [4:0]    core_sel_a;
    logic [5:0]    core_sel_b;
    logic          core_we;
    logic [5:0]    core_wsel;
    logic [DW-1:0] core_wdata;
    logic          core_stall;
    logic          dbg_valid;
    logic          dbg_ready;
    logic          dbg_write;
    logic [5:0]    dbg_addr;
    logic [DW-1:0] dbg_wdata;
    logic          dbg_rvalid;
    logic          dbg_rready;
    logic [DW-1:0] dbg_rdata;
    logic          dbg_err;
    logic [4:0]    Sel_A;
    logic [5:0]    Sel_B;
    logic [DW-1:0] Data_B;
    logic          rf_we;
    logic [5:0]    rf_wsel;
    logic [DW-1:0] rf_wdata;

    logic [DW-1:0] rf [64];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign Data_B = rf[Sel_B];

    always @(posedge clk) begin
        if (rf_we) rf[rf_wsel] <= rf_wdata;
    end

    regfile_access_sched #(
        .DW           (DW),
        .STARVE_LIMIT (4)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .core_req   (core_req),
        .core_sel_a (core_sel_a),
        .core_sel_b (core_sel_b),
        .core_we    (core_we),
        .core_wsel  (core_wsel),
        .core_wdata (core_wdata),
        .core_stall (core_stall),
        .dbg_valid  (dbg_valid),
        .dbg_ready  (dbg_ready),
        .dbg_write  (dbg_write),
        .dbg_addr   (dbg_addr),
        .dbg_wdata  (dbg_wdata),
        .dbg_rvalid (dbg_rvalid),
        .dbg_rready (dbg_rready),
        .dbg_rdata  (dbg_rdata),
        .dbg_err    (dbg_err),
        .Sel_A      (Sel_A),
        .Sel_B      (Sel_B),
        .Data_B     (Data_B),
        .rf_we      (rf_we),
        .rf_wsel    (rf_wsel),
        .rf_wdata   (rf_wdata)
    );

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) rf[i] = DW'(i * 16'h0101);
        rf[5] = 16'hBEEF;

        reset_n    = 1'b0;
        core_req   = 1'b1;
        core_sel_a = 5'd0;
        core_sel_b = 6'd0;
        core_we    = 1'b1;
        core_wsel  = 6'd3;
        core_wdata = 16'h5555;
        dbg_valid  = 1'b0;
        dbg_write  = 1'b0;
        dbg_addr   = 6'd0;
        dbg_wdata  = '0;
        dbg_rready = 1'b0;

        // reset state
        tick();
        #1;
        chk("rst_rf_we", rf_we, 0);
        chk("rst_stall", core_stall, 0);
        chk("rst_ready", dbg_ready, 1);
        chk("rst_rvalid", dbg_rvalid, 0);
        chk("rst_rdata", dbg_rdata, 0);
        chk("rst_err", dbg_err, 0);
        tick();
        reset_n = 1'b1;
        core_req = 1'b0;
        core_we  = 1'b0;

        // 1: debug read r5, core idle
        tick();
        core_sel_a = 5'd9;
        dbg_valid = 1'b1;
        dbg_write = 1'b0;
        dbg_addr  = 6'd5;
        #1;
        chk("t1_ready_idle", dbg_ready, 1);
        tick();
        dbg_valid = 1'b0;
        #1;
        chk("t1_ready_wait", dbg_ready, 0);
        chk("t1_selb", Sel_B, 5);
        chk("t1_sela", Sel_A, 9);
        chk("t1_stall", core_stall, 0);
        chk("t1_rvalid_wait", dbg_rvalid, 0);
        tick();
        chk("t1_rvalid", dbg_rvalid, 1);
        chk("t1_rdata", dbg_rdata, 16'hBEEF);
        chk("t1_err", dbg_err, 0);
        dbg_rready = 1'b1;
        tick();
        dbg_rready = 1'b0;
        #1;
        chk("t1_rvalid_done", dbg_rvalid, 0);
        chk("t1_ready_done", dbg_ready, 1);

        // 2: debug write r34 under continuous core traffic
        core_req   = 1'b1;
        core_we    = 1'b0;
        core_sel_b = 6'd7;
        dbg_valid  = 1'b1;
        dbg_write  = 1'b1;
        dbg_addr   = 6'd34;
        dbg_wdata  = 16'h1234;
        tick();
        dbg_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t2_core_wins_stall", core_stall, 0);
            chk("t2_core_wins_selb", Sel_B, 7);
            chk("t2_core_wins_we", rf_we, 0);
            tick();
        end
        #1;
        chk("t2_stall", core_stall, 1);
        chk("t2_rf_we", rf_we, 1);
        chk("t2_rf_wsel", rf_wsel, 34);
        chk("t2_rf_wdata", rf_wdata, 16'h1234);
        tick();
        chk("t2_rvalid", dbg_rvalid, 1);
        chk("t2_err", dbg_err, 0);
        chk("t2_rdata", dbg_rdata, 0);
        chk("t2_stall_resp", core_stall, 0);
        chk("t2_rf34", rf[34], 16'h1234);
        dbg_rready = 1'b1;
        tick();
        dbg_rready = 1'b0;
        core_req   = 1'b0;

        // 3: write to read-only PI0, read of unmapped 40
        dbg_valid = 1'b1;
        dbg_write = 1'b1;
        dbg_addr  = 6'd28;
        dbg_wdata = 16'hAAAA;
        tick();
        dbg_valid = 1'b0;
        #1;
        chk("t3_pi0_we", rf_we, 0);
        chk("t3_pi0_stall", core_stall, 0);
        tick();
        chk("t3_pi0_rvalid", dbg_rvalid, 1);
        chk("t3_pi0_err", dbg_err, 1);
        chk("t3_pi0_rf", rf[28], 16'h1C1C);
        dbg_rready = 1'b1;
        tick();
        dbg_rready = 1'b0;
        core_req  = 1'b1;
        dbg_valid = 1'b1;
        dbg_write = 1'b0;
        dbg_addr  = 6'd40;
        tick();
        dbg_valid = 1'b0;
        #1;
        chk("t3_r40_stall", core_stall, 0);
        tick();
        chk("t3_r40_rvalid", dbg_rvalid, 1);
        chk("t3_r40_err", dbg_err, 1);
        chk("t3_r40_rdata", dbg_rdata, 0);
        dbg_rready = 1'b1;
        tick();
        dbg_rready = 1'b0;

        // 4: core write filtering
        core_req   = 1'b1;
        core_we    = 1'b1;
        core_wsel  = 6'd29;
        core_wdata = 16'h7777;
        #1;
        chk("t4_pi1_we", rf_we, 0);
        core_wsel = 6'd33;
        #1;
        chk("t4_r33_we", rf_we, 1);
        chk("t4_r33_wsel", rf_wsel, 33);
        chk("t4_r33_wdata", rf_wdata, 16'h7777);
        core_wsel = 6'd30;
        #1;
        chk("t4_r30_we", rf_we, 0);
        core_wsel = 6'd27;
        core_req  = 1'b0;
        #1;
        chk("t4_noreq_we", rf_we, 0);
        core_we = 1'b0;

        // 5: response held while host is not ready
        dbg_valid = 1'b1;
        dbg_write = 1'b0;
        dbg_addr  = 6'd5;
        tick();
        dbg_addr = 6'd12;
        tick();
        for (int i = 0; i < 10; i++) begin
            chk("t5_rvalid_hold", dbg_rvalid, 1);
            chk("t5_rdata_hold", dbg_rdata, 16'hBEEF);
            chk("t5_ready_hold", dbg_ready, 0);
            tick();
        end
        dbg_valid  = 1'b0;
        dbg_rready = 1'b1;
        tick();
        dbg_rready = 1'b0;
        #1;
        chk("t5_ready_after", dbg_ready, 1);
        chk("t5_rvalid_after", dbg_rvalid, 0);

        // 6: reset while a write is starved
        core_req  = 1'b1;
        dbg_valid = 1'b1;
        dbg_write = 1'b1;
        dbg_addr  = 6'd3;
        dbg_wdata = 16'hDEAD;
        tick();
        dbg_valid = 1'b0;
        tick();
        chk("t6_wait_ready", dbg_ready, 0);
        reset_n = 1'b0;
        #1;
        chk("t6_rst_rvalid", dbg_rvalid, 0);
        chk("t6_rst_ready", dbg_ready, 1);
        chk("t6_rst_we", rf_we, 0);
        chk("t6_rst_stall", core_stall, 0);
        tick();
        reset_n  = 1'b1;
        core_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk("t6_no_we", rf_we, 0);
            chk("t6_ready", dbg_ready, 1);
            tick();
        end
        chk("t6_rf3", rf[3], 16'h0303);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
